// File: rtl/uart_frame_parser.sv
// Framed-packet parser behind the UART receiver: 55 AA LEN payload CSUM.
// Validated payload is replayed on a valid/ready stream; status is reported as one-cycle pulses.
module uart_frame_parser #(
  parameter int unsigned MAX_LEN  = 16,
  parameter int unsigned UART_BPS = 9600,
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned TO_BYTES = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] pi_data,
  input  logic       pi_flag,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  output logic       frm_ok,
  output logic       frm_err,
  output logic       to_err,
  output logic       drop_err
);

  localparam int unsigned TO_CYC = (CLK_FREQ / UART_BPS) * 10 * TO_BYTES;
  localparam int unsigned TMR_W  = 20;
  localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1);
  localparam int unsigned IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR2, S_LEN, S_DATA, S_CSUM, S_SEND
  } state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [7:0]        sum_q, sum_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  rd_q, rd_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              ok_q, ok_d;
  logic              err_q, err_d;
  logic              to_q, to_d;
  logic              drop_q, drop_d;
  logic [7:0]        mem_q [MAX_LEN];
  logic              mem_we_c;
  logic              tmr_active_c;

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    rd_d        = rd_q;
    tmr_d       = '0;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    out_last_d  = out_last_q;
    ok_d        = 1'b0;
    err_d       = 1'b0;
    to_d        = 1'b0;
    drop_d      = 1'b0;
    mem_we_c    = 1'b0;

    tmr_active_c = (state_q == S_HDR2) || (state_q == S_LEN) ||
                   (state_q == S_DATA) || (state_q == S_CSUM);

    // A byte arriving on the terminal count wins over the timeout
    if (tmr_active_c && !pi_flag) begin
      if (tmr_q == TMR_W'(TO_CYC - 1)) begin
        to_d    = 1'b1;
        state_d = S_IDLE;
      end else begin
        tmr_d = tmr_q + TMR_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (pi_flag && pi_data == 8'h55) state_d = S_HDR2;
      end
      S_HDR2: begin
        if (pi_flag) begin
          if (pi_data == 8'hAA)      state_d = S_LEN;
          else if (pi_data != 8'h55) state_d = S_IDLE;
        end
      end
      S_LEN: begin
        if (pi_flag) begin
          if (pi_data == 8'h00 || pi_data > 8'(MAX_LEN)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            len_d   = LEN_W'(pi_data);
            sum_d   = pi_data;
            idx_d   = '0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (pi_flag) begin
          mem_we_c = 1'b1;
          sum_d    = sum_q + pi_data;
          idx_d    = idx_q + IDX_W'(1);
          if (LEN_W'(idx_q) == len_q - LEN_W'(1)) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (pi_flag) begin
          if (pi_data == sum_q) begin
            ok_d        = 1'b1;
            rd_d        = '0;
            out_valid_d = 1'b1;
            out_data_d  = mem_q[0];
            out_last_d  = (len_q == LEN_W'(1));
            state_d     = S_SEND;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_SEND: begin
        out_valid_d = 1'b1;
        drop_d      = pi_flag;
        if (out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
          end else begin
            rd_d       = rd_q + IDX_W'(1);
            out_data_d = mem_q[rd_q + IDX_W'(1)];
            out_last_d = (LEN_W'(rd_q) + LEN_W'(2) == len_q);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      rd_q        <= '0;
      tmr_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
      to_q        <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      rd_q        <= rd_d;
      tmr_q       <= tmr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
      to_q        <= to_d;
      drop_q      <= drop_d;
    end
  end

  // Payload buffer
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < int'(MAX_LEN); i++) mem_q[i] <= '0;
    end else if (mem_we_c) begin
      mem_q[idx_q] <= pi_data;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign frm_ok    = ok_q;
  assign frm_err   = err_q;
  assign to_err    = to_q;
  assign drop_err  = drop_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: frame vector table plus stall, drop, timeout and reset sequences.
module tb_uart_frame_parser;

  localparam int unsigned TO_CYC = 400;  // (192000/9600)*10*2

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [7:0] pi_data = 8'h00;
  logic       pi_flag = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_valid, out_last, frm_ok, frm_err, to_err, drop_err;

  uart_frame_parser #(
    .MAX_LEN(16), .UART_BPS(9600), .CLK_FREQ(192_000), .TO_BYTES(2)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .pi_data(pi_data), .pi_flag(pi_flag), .out_ready(out_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .frm_ok(frm_ok), .frm_err(frm_err), .to_err(to_err), .drop_err(drop_err)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int           n;      // number of input bytes, right-aligned in bytes
    logic [159:0] bytes;
    int           ok;
    int           err;
    int           nout;   // payload bytes expected, right-aligned in outs
    logic [127:0] outs;
  } vec_t;

  vec_t vecs[8];

  int total = 0;
  int bad   = 0;
  int n_ok = 0, n_err = 0, n_to = 0, n_drop = 0, n_unstable = 0;
  logic [8:0] rx_q[$];
  logic       stall_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_last = 1'b0;

  // Mid-cycle observer: pulses, transfers and hold-stability under back-pressure
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      stall_prev <= 1'b0;
    end else begin
      if (frm_ok)   n_ok   <= n_ok + 1;
      if (frm_err)  n_err  <= n_err + 1;
      if (to_err)   n_to   <= n_to + 1;
      if (drop_err) n_drop <= n_drop + 1;
      if (stall_prev && (!out_valid || out_data != prev_data || out_last != prev_last))
        n_unstable <= n_unstable + 1;
      if (out_valid && out_ready) rx_q.push_back({out_last, out_data});
      stall_prev <= out_valid && !out_ready;
      prev_data  <= out_data;
      prev_last  <= out_last;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    pi_data = b;
    pi_flag = 1'b1;
    tick();
    pi_flag = 1'b0;
    tick();
  endtask

  task automatic send_vec(input int i);
    for (int k = 0; k < vecs[i].n; k++)
      send_byte(vecs[i].bytes[8*(vecs[i].n-1-k) +: 8]);
  endtask

  task automatic chk_rx(input string tag, input int nexp, input logic [127:0] outs);
    chk({tag, " count"}, rx_q.size(), nexp);
    for (int j = 0; j < nexp; j++) begin
      if (rx_q.size() > 0) begin
        logic [8:0] r;
        r = rx_q.pop_front();
        chk($sformatf("%s byte%0d", tag, j), int'(r[7:0]), int'(outs[8*(nexp-1-j) +: 8]));
        chk($sformatf("%s last%0d", tag, j), int'(r[8]), (j == nexp-1) ? 1 : 0);
      end
    end
    rx_q.delete();
  endtask

  task automatic run_vec(input int i, input string tag);
    int ok0, err0, to0, drop0;
    rx_q.delete();
    out_ready = 1'b1;
    ok0 = n_ok; err0 = n_err; to0 = n_to; drop0 = n_drop;
    send_vec(i);
    repeat (40) tick();
    chk({tag, " frm_ok"}, n_ok - ok0, vecs[i].ok);
    chk({tag, " frm_err"}, n_err - err0, vecs[i].err);
    chk({tag, " to_err"}, n_to - to0, 0);
    chk({tag, " drop_err"}, n_drop - drop0, 0);
    chk_rx(tag, vecs[i].nout, vecs[i].outs);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, int'({out_valid, out_last, frm_ok, frm_err, to_err, drop_err, out_data}), 0);
  endtask

  initial begin
    int ok0, err0, to0, drop0;

    vecs[0] = '{n:7,  bytes:160'h55AA0311223369, ok:1, err:0, nout:3, outs:128'h112233};
    vecs[1] = '{n:7,  bytes:160'h55AA0311223368, ok:0, err:1, nout:0, outs:128'h0};
    vecs[2] = '{n:3,  bytes:160'h55AA00,         ok:0, err:1, nout:0, outs:128'h0};
    vecs[3] = '{n:3,  bytes:160'h55AA11,         ok:0, err:1, nout:0, outs:128'h0};
    vecs[4] = '{n:6,  bytes:160'h5555AA017E7F,   ok:1, err:0, nout:1, outs:128'h7E};
    vecs[5] = '{n:10, bytes:160'h00125513_55AA02A0B052, ok:1, err:0, nout:2, outs:128'hA0B0};
    vecs[6] = '{n:20, bytes:160'h55AA10_0102030405060708090A0B0C0D0E0F10_98,
                ok:1, err:0, nout:16, outs:128'h0102030405060708090A0B0C0D0E0F10};
    vecs[7] = '{n:5,  bytes:160'hAA017E7F00,     ok:0, err:0, nout:0, outs:128'h0};

    // Reset state
    repeat (3) tick();
    chk_all_zero("reset held");
    sys_rst_n = 1'b1;
    tick();
    chk_all_zero("after reset");

    // Table of frames, including the bad-checksum-then-good sequence
    for (int i = 0; i < 8; i++) begin
      run_vec(i, $sformatf("v%0d", i));
      if (i == 1) run_vec(0, "v1 follow-up");
    end

    // Back-pressure for 200 cycles with a byte injected during SEND
    rx_q.delete();
    out_ready = 1'b0;
    ok0 = n_ok; drop0 = n_drop;
    send_vec(0);
    repeat (200) tick();
    chk("stall valid", int'(out_valid), 1);
    chk("stall data", int'(out_data), 'h11);
    chk("stall last", int'(out_last), 0);
    chk("stall frm_ok", n_ok - ok0, 1);
    send_byte(8'h55);
    chk("stall drop_err", n_drop - drop0, 1);
    chk("stall data after drop", int'(out_data), 'h11);
    out_ready = 1'b1;
    repeat (20) tick();
    chk("stall unstable", n_unstable, 0);
    chk_rx("stall", 3, 128'h112233);

    // Byte strobe coinciding with the final transfer
    out_ready = 1'b0;
    drop0 = n_drop;
    send_vec(4);
    tick();
    chk("final valid", int'(out_valid), 1);
    chk("final last", int'(out_last), 1);
    out_ready = 1'b1;
    pi_data = 8'h55;
    pi_flag = 1'b1;
    tick();
    pi_flag = 1'b0;
    out_ready = 1'b0;
    tick();
    chk("final valid low", int'(out_valid), 0);
    chk("final drop_err", n_drop - drop0, 1);
    chk_rx("final", 1, 128'h7E);
    run_vec(5, "after final");

    // Inter-byte timeout
    to0 = n_to; err0 = n_err;
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h04);
    send_byte(8'h01); send_byte(8'h02);
    repeat (TO_CYC - 10) tick();
    chk("timeout early", n_to - to0, 0);
    repeat (20) tick();
    chk("timeout to_err", n_to - to0, 1);
    chk("timeout frm_err", n_err - err0, 0);
    chk("timeout valid", int'(out_valid), 0);
    run_vec(4, "after timeout");

    // Reset in the middle of DATA
    err0 = n_err; to0 = n_to;
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h03); send_byte(8'h11);
    #1 sys_rst_n = 1'b0;
    #1 chk_all_zero("reset in DATA");
    tick();
    sys_rst_n = 1'b1;
    tick();
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h69);
    repeat (5) tick();
    chk("reset no frm_err", n_err - err0, 0);
    chk("reset no to_err", n_to - to0, 0);
    chk("reset no output", rx_q.size(), 0);
    run_vec(0, "after reset");

    // Asynchronous reset while a byte is being offered
    out_ready = 1'b0;
    send_vec(0);
    tick();
    chk("pre-reset valid", int'(out_valid), 1);
    #1 sys_rst_n = 1'b0;
    #1 chk_all_zero("reset in SEND");
    tick();
    sys_rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (10) tick();
    chk("reset SEND no output", rx_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
